sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO that generalises the fixed-geometry block-RAM FIFO wrappers. Width and depth are parameters. A parameter selects standard or first-word-fall-through (FWFT) read mode. Programmable-full and programmable-empty thresholds are runtime inputs rather than constants, and the block provides an occupancy count and optional sticky error flags. It sits between any producer/consumer pair in one clock domain, for example capture buffers, command queues and test FIFOs.

## Interface
- Width, 18, data bits per word
- Depth, 512, words of storage; power of two, at least 4
- FirstWordFall, 0, 0 = standard read, 1 = FWFT
- CountWidth, $clog2(Depth)+1, width of count and threshold buses
- Clk  in  1  clock; all logic is on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Din  in  Width  write data
- Write  in  1  write request
- Read  in  1  read request (FWFT: acknowledge of the head word)
- Dout  out  Width  read data
- Valid  out  1  Dout holds a valid word
- Full / Empty  out  1  occupancy flags
- ProgFullThresh / ProgEmptyThresh  in  CountWidth  runtime thresholds
- ProgFull / ProgEmpty  out  1  threshold flags
- DataCount  out  CountWidth  words held, 0..Depth
- ClrErr  in  1  clears the sticky error flags
- Overflow / Underflow  out  1  sticky error flags (macro only)

## Operation
- Write is accepted only when Full=0. A write while Full is dropped and the contents are unchanged.
- Read is accepted only when Empty=0. A read while Empty is ignored and the pointers are unchanged.
- When Read and Write are both accepted in one cycle, DataCount is unchanged and both pointers advance.
- In standard mode, a Write while Empty with a simultaneous Read accepts only the write.
- A Write while Full is dropped even if Read is asserted in the same cycle.
- Pointers are log2(Depth) bits and wrap modulo Depth. DataCount saturates at neither end, because the accept rules prevent over- and under-run.
- Full = (DataCount==Depth). Empty = (DataCount==0) in standard mode; Empty = !Valid in FWFT mode.
- ProgFull = (DataCount >= ProgFullThresh). ProgEmpty = (DataCount <= ProgEmptyThresh). Both are registered and updated on the same edge as DataCount. A threshold change takes effect on the next edge.
- Standard mode: an accepted Read presents the head word on Dout with Valid=1 for exactly one cycle after the edge. Dout holds its value afterwards.
- FWFT mode:
  - The head word is prefetched into an output register. Valid=1 while that register is loaded.
  - Read with Valid=1 consumes the word, and the next word (if any) is loaded without a bubble.
  - DataCount includes the output-register word. Total capacity is Depth.
- Reset (asynchronous, any time) sets:
  - DataCount=0, Empty=1, Full=0, ProgEmpty=1, ProgFull=0
  - Valid=0, Dout=0
  - Overflow=0, Underflow=0
  - pointers=0
- RAM contents are not cleared by reset. An in-flight read is discarded.

## Timing
- Write to read-visible latency:
  - Standard mode: a word written at edge N can be read by a Read in cycle N+1; its data appears after edge N+2.
  - FWFT mode: a write at edge N into an empty FIFO gives Valid=1 and the word on Dout after edge N+2.
- Flag latency: Full, Empty, ProgFull, ProgEmpty and DataCount reflect an accepted operation one edge later.
- Read data path: one registered RAM read. No combinational path from Read or Write to any output.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - Overflow sets on a write attempted while Full.
  - Underflow sets on a read attempted while Empty (FWFT: while Valid=0).
  - Both are sticky until ClrErr=1 at an edge. If ClrErr and a new error occur in the same cycle, the error wins.
- FIFO_ERR_FLAGS_EN undefined: Overflow and Underflow are tied to 0, ClrErr is unused, and no error logic is present.

## Structure
- Package fifo_pkg holds the default width and depth constants and a function computing CountWidth. It is shared with future FIFO variants.
- Sub-module fifo_ram: simple dual-port RAM (one write port, one registered read port), Width x Depth, inferable as block RAM. All control, flag and prefetch logic lives in sync_fifo_param.

## Test plan
- Reset sequence:
  - Stimulus: Reset_n low mid-stream with DataCount=7.
  - Response: all outputs at their reset values immediately; DataCount=0 and Empty=1 after release.
- Fill and drain (Depth=16, standard mode):
  - Stimulus: write 0x00..0x0F, then read 16 times.
  - Response: Full=1 after the 16th write edge; Dout sequence 0x00..0x0F, each with a one-cycle Valid pulse; Empty=1 at the end.
- Thresholds:
  - Stimulus: ProgFullThresh=14, ProgEmptyThresh=5; count goes 0→16→0.
  - Response: ProgEmpty=1 at counts 0..5; ProgFull=1 at counts 14..16.
- Simultaneous operations:
  - Stimulus: Read and Write together at DataCount=8.
  - Response: DataCount stays 8; data order is preserved across the pointer wrap after 40 such cycles.
- FWFT:
  - Stimulus: single write of 0x2A5 into an empty FIFO, then Read on the first cycle Valid=1.
  - Response: Valid=1 and Dout=0x2A5 two edges after the write; Valid=0 and Empty=1 after the Read.
- Errors (macro defined):
  - Stimulus: write while Full; read while Empty; then ClrErr.
  - Response: Overflow=1 and Underflow=1 persist with contents unchanged; both clear one edge after ClrErr.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
package fifo_pkg;

  localparam int unsigned DefaultWidth = 18;
  localparam int unsigned DefaultDepth = 512;

  // Count and threshold buses must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fifo_ram #(
  parameter int unsigned Width = 18,
  parameter int unsigned Depth = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(Depth)-1:0] rd_addr_i,
  output logic [Width-1:0]         rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  // Storage array; deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// runtime programmable thresholds and an occupancy count.
// Define FIFO_ERR_FLAGS_EN to build the sticky Overflow/Underflow flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned Width         = DefaultWidth,
  parameter int unsigned Depth         = DefaultDepth,
  parameter bit          FirstWordFall = 1'b0,
  parameter int unsigned CountWidth    = count_width(Depth)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [Width-1:0]      Din,
  input  logic                  Write,
  input  logic                  Read,
  output logic [Width-1:0]      Dout,
  output logic                  Valid,
  output logic                  Full,
  output logic                  Empty,
  input  logic [CountWidth-1:0] ProgFullThresh,
  input  logic [CountWidth-1:0] ProgEmptyThresh,
  output logic                  ProgFull,
  output logic                  ProgEmpty,
  output logic [CountWidth-1:0] DataCount,
  input  logic                  ClrErr,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0] count_q, count_d, ram_avail;
  logic                  full_q, empty_q, prog_full_q, prog_empty_q;
  logic                  valid_q, pend_q;
  logic [Width-1:0]      out_q, ram_rdata;
  logic                  head_ok, wr_acc, rd_acc, ram_rd, load;

  // Accept rules, prefetch control and next occupancy.
  always_comb begin
    head_ok   = FirstWordFall ? valid_q : !empty_q;
    wr_acc    = Write && !full_q;
    rd_acc    = Read && head_ok;
    // Words still in RAM, excluding the RAM output stage and the output register.
    ram_avail = count_q - CountWidth'(valid_q) - CountWidth'(pend_q);
    // A pending RAM word moves to the output register when that register frees up.
    load      = pend_q && (!valid_q || rd_acc);
    if (FirstWordFall) begin
      // Never overwrite the RAM output stage while it still holds an unloaded word.
      ram_rd = (ram_avail != '0) && (!pend_q || load);
    end else begin
      ram_rd = rd_acc;
    end
    count_d = count_q + CountWidth'(wr_acc) - CountWidth'(rd_acc);
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (ram_rd) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      count_q      <= count_d;
      full_q       <= (count_d == CountWidth'(Depth));
      empty_q      <= (count_d == '0);
      prog_full_q  <= (count_d >= ProgFullThresh);
      prog_empty_q <= (count_d <= ProgEmptyThresh);
    end
  end

  // Read-side output: one-cycle Valid pulse, or FWFT prefetch register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      out_q   <= '0;
    end else if (FirstWordFall) begin
      if (load) begin
        out_q   <= ram_rdata;
        valid_q <= 1'b1;
      end else if (rd_acc) begin
        valid_q <= 1'b0;
      end
      pend_q <= ram_rd || (pend_q && !load);
    end else begin
      valid_q <= rd_acc;
      pend_q  <= 1'b0;
    end
  end

  fifo_ram #(
    .Width(Width),
    .Depth(Depth)
  ) u_ram (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(Din),
    .rd_en_i  (ram_rd),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(ram_rdata)
  );

  assign Dout      = FirstWordFall ? out_q : ram_rdata;
  assign Valid     = valid_q;
  assign Full      = full_q;
  assign Empty     = FirstWordFall ? !valid_q : empty_q;
  assign ProgFull  = prog_full_q;
  assign ProgEmpty = prog_empty_q;
  assign DataCount = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !ClrErr) || (Write && full_q);
      unf_q <= (unf_q && !ClrErr) || (Read && !head_ok);
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = ClrErr;
  assign Overflow       = 1'b0;
  assign Underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT instance, Depth 16.
module tb_sync_fifo_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int Dep = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_s, r_s, w_f, r_f, clr;
  logic [17:0] d_s, d_f;
  logic [4:0]  pft, pet;

  logic [17:0] dout_s, dout_f;
  logic        valid_s, full_s, empty_s, pf_s, pe_s, ovf_s, unf_s;
  logic        valid_f, full_f, empty_f, pf_f, pe_f, ovf_f, unf_f;
  logic [4:0]  cnt_s, cnt_f;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.Width(18), .Depth(Dep), .FirstWordFall(1'b0)) u_std (
    .Clk(clk), .Reset_n(rst_n), .Din(d_s), .Write(w_s), .Read(r_s), .Dout(dout_s),
    .Valid(valid_s), .Full(full_s), .Empty(empty_s), .ProgFullThresh(pft),
    .ProgEmptyThresh(pet), .ProgFull(pf_s), .ProgEmpty(pe_s), .DataCount(cnt_s),
    .ClrErr(clr), .Overflow(ovf_s), .Underflow(unf_s)
  );

  sync_fifo_param #(.Width(18), .Depth(Dep), .FirstWordFall(1'b1)) u_fwft (
    .Clk(clk), .Reset_n(rst_n), .Din(d_f), .Write(w_f), .Read(r_f), .Dout(dout_f),
    .Valid(valid_f), .Full(full_f), .Empty(empty_f), .ProgFullThresh(pft),
    .ProgEmptyThresh(pet), .ProgFull(pf_f), .ProgEmpty(pe_f), .DataCount(cnt_f),
    .ClrErr(clr), .Overflow(ovf_f), .Underflow(unf_f)
  );

  // Reference model: word queues plus the FWFT visibility rule
  // "head visible at the later of (its write edge + 2) and the edge that consumed its predecessor".
  typedef struct { logic [17:0] data; int wr; } fw_t;
  logic [17:0] ms_q[$];
  fw_t         mf_q[$];
  logic [17:0] ms_dout;
  logic        ms_valid, ms_pf, ms_pe, ms_ovf, ms_unf;
  logic        mf_pf, mf_pe, mf_ovf, mf_unf;
  int          mf_last = 0;
  int          edge_n = 0;

  function automatic bit mf_visible(input int t);
    int rdy;
    if (mf_q.size() == 0) return 1'b0;
    rdy = mf_q[0].wr + 2;
    if (mf_last > rdy) rdy = mf_last;
    return rdy <= t;
  endfunction

  task automatic model_reset();
    ms_q.delete();
    mf_q.delete();
    ms_dout = '0; ms_valid = 1'b0; ms_pf = 1'b0; ms_pe = 1'b1; ms_ovf = 1'b0; ms_unf = 1'b0;
    mf_pf = 1'b0; mf_pe = 1'b1; mf_ovf = 1'b0; mf_unf = 1'b0; mf_last = 0;
  endtask

  task automatic model_step();
    bit sfull, sempty, vb, ffull, eo, eu;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sfull  = (ms_q.size() == Dep);
    sempty = (ms_q.size() == 0);
    eo = w_s && sfull;
    eu = r_s && sempty;
    ms_valid = 1'b0;
    if (r_s && !sempty) begin
      ms_dout  = ms_q.pop_front();
      ms_valid = 1'b1;
    end
    if (w_s && !sfull) ms_q.push_back(d_s);
    ms_pf  = ms_q.size() >= int'(pft);
    ms_pe  = ms_q.size() <= int'(pet);
    ms_ovf = ErrEn && ((ms_ovf && !clr) || eo);
    ms_unf = ErrEn && ((ms_unf && !clr) || eu);

    vb    = mf_visible(edge_n - 1);
    ffull = (mf_q.size() == Dep);
    eo = w_f && ffull;
    eu = r_f && !vb;
    if (r_f && vb) begin
      mf_q.delete(0);
      mf_last = edge_n;
    end
    if (w_f && !ffull) mf_q.push_back('{data: d_f, wr: edge_n});
    mf_pf  = mf_q.size() >= int'(pft);
    mf_pe  = mf_q.size() <= int'(pet);
    mf_ovf = ErrEn && ((mf_ovf && !clr) || eo);
    mf_unf = ErrEn && ((mf_unf && !clr) || eu);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_cnt_s", cnt_s, 0);    chk("rst_empty_s", empty_s, 1); chk("rst_full_s", full_s, 0);
    chk("rst_pe_s", pe_s, 1);      chk("rst_pf_s", pf_s, 0);       chk("rst_valid_s", valid_s, 0);
    chk("rst_dout_s", dout_s, 0);  chk("rst_ovf_s", ovf_s, 0);     chk("rst_unf_s", unf_s, 0);
    chk("rst_cnt_f", cnt_f, 0);    chk("rst_empty_f", empty_f, 1); chk("rst_full_f", full_f, 0);
    chk("rst_pe_f", pe_f, 1);      chk("rst_pf_f", pf_f, 0);       chk("rst_valid_f", valid_f, 0);
    chk("rst_dout_f", dout_f, 0);  chk("rst_ovf_f", ovf_f, 0);     chk("rst_unf_f", unf_f, 0);
  endtask

  task automatic compare_all();
    bit vis;
    chk("m_cnt_s", cnt_s, ms_q.size());        chk("m_full_s", full_s, ms_q.size() == Dep);
    chk("m_empty_s", empty_s, ms_q.size() == 0); chk("m_valid_s", valid_s, ms_valid);
    chk("m_dout_s", dout_s, ms_dout);          chk("m_pf_s", pf_s, ms_pf);
    chk("m_pe_s", pe_s, ms_pe);                chk("m_ovf_s", ovf_s, ms_ovf);
    chk("m_unf_s", unf_s, ms_unf);
    vis = mf_visible(edge_n);
    chk("m_cnt_f", cnt_f, mf_q.size());        chk("m_full_f", full_f, mf_q.size() == Dep);
    chk("m_valid_f", valid_f, vis);            chk("m_empty_f", empty_f, !vis);
    if (vis) chk("m_dout_f", dout_f, mf_q[0].data);
    chk("m_pf_f", pf_f, mf_pf);                chk("m_pe_f", pe_f, mf_pe);
    chk("m_ovf_f", ovf_f, mf_ovf);             chk("m_unf_f", unf_f, mf_unf);
  endtask

  typedef struct {
    logic wr; logic rd; logic [17:0] din;
    logic [4:0] cnt; logic full; logic empty; logic valid; logic [17:0] dout; logic pe;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    rd    din      cnt   full  empty valid dout     pe
    vecs[0] = '{1'b1, 1'b0, 18'h011, 5'd1, 1'b0, 1'b0, 1'b0, 18'h000, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 18'h022, 5'd1, 1'b0, 1'b0, 1'b1, 18'h011, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 18'h000, 5'd0, 1'b0, 1'b1, 1'b1, 18'h022, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 18'h000, 5'd0, 1'b0, 1'b1, 1'b0, 18'h022, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 18'h033, 5'd1, 1'b0, 1'b0, 1'b0, 18'h022, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 18'h044, 5'd2, 1'b0, 1'b0, 1'b0, 18'h022, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 18'h000, 5'd2, 1'b0, 1'b0, 1'b0, 18'h022, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 18'h000, 5'd1, 1'b0, 1'b0, 1'b1, 18'h033, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 18'h000, 5'd0, 1'b0, 1'b1, 1'b1, 18'h044, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 18'h000, 5'd0, 1'b0, 1'b1, 1'b0, 18'h044, 1'b1};

    rst_n = 1'b1; w_s = 0; r_s = 0; w_f = 0; r_f = 0; clr = 0; d_s = '0; d_f = '0;
    pft = 5'd14; pet = 5'd5;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    tick();
    tick();
    rst_n = 1'b1;

    // Directed table on the standard-mode instance.
    for (int i = 0; i < 10; i++) begin
      w_s = vecs[i].wr; r_s = vecs[i].rd; d_s = vecs[i].din;
      tick();
      chk($sformatf("tbl%0d_cnt", i), cnt_s, vecs[i].cnt);
      chk($sformatf("tbl%0d_full", i), full_s, vecs[i].full);
      chk($sformatf("tbl%0d_empty", i), empty_s, vecs[i].empty);
      chk($sformatf("tbl%0d_valid", i), valid_s, vecs[i].valid);
      chk($sformatf("tbl%0d_dout", i), dout_s, vecs[i].dout);
      chk($sformatf("tbl%0d_pe", i), pe_s, vecs[i].pe);
    end
    w_s = 0; r_s = 0; clr = 1;
    tick();
    clr = 0;
    chk("tbl_clr_ovf", ovf_s, 0); chk("tbl_clr_unf", unf_s, 0);

    // Fill to full with threshold checks.
    for (int i = 0; i < 16; i++) begin
      w_s = 1; d_s = 18'(i);
      tick();
      chk("fill_cnt", cnt_s, i + 1);         chk("fill_full", full_s, i == 15);
      chk("fill_pf", pf_s, (i + 1) >= 14);   chk("fill_pe", pe_s, (i + 1) <= 5);
      chk("fill_empty", empty_s, 0);
    end
    d_s = 18'h3FF;
    tick();
    chk("ovf_cnt", cnt_s, 16); chk("ovf_full", full_s, 1);
    chk("ovf_set", ovf_s, ErrEn); chk("ovf_unf", unf_s, 0);
    r_s = 1; d_s = 18'h3FE;
    tick();
    chk("wrfull_rd_cnt", cnt_s, 15); chk("wrfull_rd_dout", dout_s, 0);
    chk("wrfull_rd_valid", valid_s, 1); chk("wrfull_rd_pf", pf_s, 1);
    chk("ovf_hold", ovf_s, ErrEn);
    w_s = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("drain_dout", dout_s, i);          chk("drain_valid", valid_s, 1);
      chk("drain_cnt", cnt_s, 15 - i);       chk("drain_pf", pf_s, (15 - i) >= 14);
      chk("drain_pe", pe_s, (15 - i) <= 5);
    end
    tick();
    chk("unf_valid", valid_s, 0); chk("unf_dout_hold", dout_s, 15); chk("unf_empty", empty_s, 1);
    chk("unf_set", unf_s, ErrEn); chk("unf_ovf_hold", ovf_s, ErrEn);
    r_s = 0;
    tick();
    chk("err_persist_ovf", ovf_s, ErrEn); chk("err_persist_unf", unf_s, ErrEn);
    clr = 1;
    tick();
    chk("err_clr_ovf", ovf_s, 0); chk("err_clr_unf", unf_s, 0);
    r_s = 1;
    tick();
    chk("err_wins_unf", unf_s, ErrEn); chk("err_wins_ovf", ovf_s, 0);
    r_s = 0;
    tick();
    clr = 0;
    chk("err_wins_clr", unf_s, 0);

    // Simultaneous read/write at count 8 across pointer wrap.
    for (int k = 0; k < 8; k++) begin
      w_s = 1; d_s = 18'h100 + 18'(k);
      tick();
    end
    chk("sim_pre_cnt", cnt_s, 8);
    r_s = 1;
    for (int j = 0; j < 40; j++) begin
      d_s = 18'h108 + 18'(j);
      tick();
      chk("sim_cnt", cnt_s, 8); chk("sim_dout", dout_s, 18'h100 + 18'(j));
      chk("sim_valid", valid_s, 1);
    end
    w_s = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("sim_tail", dout_s, 18'h128 + 18'(j));
    end
    r_s = 0;
    tick();
    chk("sim_empty", empty_s, 1);

    // Asynchronous reset mid-stream at count 7.
    for (int k = 0; k < 7; k++) begin
      w_s = 1; d_s = 18'h200 + 18'(k); r_f = (k == 0);
      tick();
    end
    w_s = 0; r_f = 0;
    chk("pre_rst_cnt", cnt_s, 7); chk("pre_rst_unf_f", unf_f, ErrEn);
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    tick();
    check_reset_state();
    rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", cnt_s, 0); chk("post_rst_empty", empty_s, 1);

    // FWFT single word: visible two edges after the write.
    w_f = 1; d_f = 18'h2A5;
    tick();
    w_f = 0;
    chk("fw_n_valid", valid_f, 0); chk("fw_n_cnt", cnt_f, 1); chk("fw_n_empty", empty_f, 1);
    tick();
    chk("fw_n1_valid", valid_f, 0);
    tick();
    chk("fw_n2_valid", valid_f, 1); chk("fw_n2_dout", dout_f, 18'h2A5);
    chk("fw_n2_empty", empty_f, 0);
    r_f = 1;
    tick();
    r_f = 0;
    chk("fw_rd_valid", valid_f, 0); chk("fw_rd_empty", empty_f, 1); chk("fw_rd_cnt", cnt_f, 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      int pw, pr;
      case ((i / 100) % 3)
        0:       begin pw = 75; pr = 25; end
        1:       begin pw = 25; pr = 75; end
        default: begin pw = 50; pr = 50; end
      endcase
      w_s = ($urandom_range(99) < pw); r_s = ($urandom_range(99) < pr);
      w_f = ($urandom_range(99) < pw); r_f = ($urandom_range(99) < pr);
      d_s = 18'($urandom()); d_f = 18'($urandom());
      clr = ($urandom_range(31) == 0);
      if (i % 64 == 0) begin
        pft = 5'($urandom_range(16));
        pet = 5'($urandom_range(16));
      end
      tick();
      compare_all();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
